// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute channels of the decode stage.
interface decode_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [REG_W-1:0] out_rd;
    logic [REG_W-1:0] out_rs1;
    logic [REG_W-1:0] out_rs2;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_rd_we;
    logic             out_illegal;

    // Producer of instructions / consumer of decoded entries
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
    );

    // Decode stage itself
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: combinational field/immediate decode into a 2-entry skid buffer.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             rd_we;
        logic             illegal;
    } entry_t;

    entry_t      dec;
    logic        use_rd, use_rs1, use_rs2, use_f3, use_f7;
    logic        idx_bad;
    logic [31:0] imm32;
    logic [31:0] inst;

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic   in_ready_q, in_ready_d;
    logic   in_xfer, out_xfer;

    assign inst = bus.in_inst;

    // Decode the incoming instruction; unused fields forced to zero
    always_comb begin
        dec     = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_f3  = 1'b0;
        use_f7  = 1'b0;
        imm32   = '0;
        idx_bad = 1'b0;
        dec.fmt = FMT_NONE;
        unique case (inst[6:0])
            OP_R: begin
                dec.fmt = FMT_R;
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; use_f7 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                dec.fmt = FMT_I;
                use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                use_rd = 1'b1;
                imm32 = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                use_rd = 1'b1;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                dec.fmt     = FMT_NONE;
                dec.illegal = 1'b1;
            end
        endcase

        // Reduced register file: a used index above the file is illegal
        idx_bad = (REG_W < 5) && ((use_rd && inst[11]) || (use_rs1 && inst[19]) ||
                                  (use_rs2 && inst[24]));

        dec.pc      = bus.in_pc;
        dec.rd      = use_rd  ? inst[7  +: REG_W] : '0;
        dec.rs1     = use_rs1 ? inst[15 +: REG_W] : '0;
        dec.rs2     = use_rs2 ? inst[20 +: REG_W] : '0;
        dec.funct3  = use_f3  ? inst[14:12] : 3'b0;
        dec.funct7  = use_f7  ? inst[31:25] : 7'b0;
        dec.imm     = XLEN'($signed(imm32));
        dec.illegal = dec.illegal | idx_bad;
        dec.rd_we   = use_rd && (inst[11:7] != 5'd0) && !idx_bad;
    end

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = main_v_q && bus.out_ready;

    // Skid buffer next state: main feeds outputs, skid catches the entry accepted during a stall
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || out_xfer) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_xfer;
                if (in_xfer) begin
                    main_d = dec;
                end
            end
        end else if (in_xfer) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
        in_ready_d = !skid_v_d;
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_v_q;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_funct3  = main_q.funct3;
    assign bus.out_funct7  = main_q.funct7;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_rd_we   = main_q.rd_we;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: RV32I instance plus an RV32E instance.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    decode_stage_if #(.XLEN(32), .REG_W(5)) ba();
    decode_stage_if #(.XLEN(32), .REG_W(4)) be();

    decode_stage #(.XLEN(32), .REG_W(5)) u_dut_i (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(ba));
    decode_stage #(.XLEN(32), .REG_W(4)) u_dut_e (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(be));

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   out_count = 0;
    exp_t sq_i[$];
    exp_t sq_e[$];
    exp_t held;
    logic hold_q = 1'b0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [2:0] fmt, input logic we,
                                input logic ill);
        exp_t e;
        e = '{pc, rd, rs1, rs2, f3, f7, imm, fmt, we, ill};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_entry(input string nm, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s pc=0x%0h: got rd=%0d rs1=%0d rs2=%0d f3=%0d f7=0x%0h imm=0x%0h fmt=%0d we=%0b ill=%0b expected rd=%0d rs1=%0d rs2=%0d f3=%0d f7=0x%0h imm=0x%0h fmt=%0d we=%0b ill=%0b",
                     nm, exp.pc, act.rd, act.rs1, act.rs2, act.f3, act.f7, act.imm, act.fmt, act.rd_we,
                     act.illegal, exp.rd, exp.rs1, exp.rs2, exp.f3, exp.f7, exp.imm, exp.fmt,
                     exp.rd_we, exp.illegal);
            if (act.pc !== exp.pc) $display("FAIL %s_pc: got 0x%0h expected 0x%0h", nm, act.pc, exp.pc);
        end
    endtask

    function automatic exp_t act_i();
        return '{ba.out_pc, ba.out_rd, ba.out_rs1, ba.out_rs2, ba.out_funct3, ba.out_funct7,
                 ba.out_imm, ba.out_fmt, ba.out_rd_we, ba.out_illegal};
    endfunction

    function automatic exp_t act_e();
        return '{be.out_pc, {1'b0, be.out_rd}, {1'b0, be.out_rs1}, {1'b0, be.out_rs2}, be.out_funct3,
                 be.out_funct7, be.out_imm, be.out_fmt, be.out_rd_we, be.out_illegal};
    endfunction

    // Monitor for the RV32I instance: pop on every output transfer, check hold stability
    always @(negedge clk) begin
        exp_t a;
        a = act_i();
        if (rst_n && hold_q && ba.out_valid) begin
            cmp_entry("hold_stable", a, held);
        end
        hold_q <= rst_n && ba.out_valid && !ba.out_ready;
        held   <= a;
        if (rst_n && ba.out_valid && ba.out_ready) begin
            out_count++;
            if (sq_i.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pc=0x%0h expected no entry", ba.out_pc);
            end else begin
                cmp_entry("entry_i", a, sq_i.pop_front());
            end
        end
    end

    // Monitor for the RV32E instance
    always @(negedge clk) begin
        if (rst_n && be.out_valid && be.out_ready) begin
            if (sq_e.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_e: got pc=0x%0h expected no entry", be.out_pc);
            end else begin
                cmp_entry("entry_e", act_e(), sq_e.pop_front());
            end
        end
    end

    // Present one instruction, push its expectation, return just after the accepting edge
    task automatic send(input bit sel_e, input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        bit ok;
        ok = 1'b0;
        if (sel_e) begin
            be.in_valid = 1'b1; be.in_inst = inst; be.in_pc = pc; sq_e.push_back(e);
        end else begin
            ba.in_valid = 1'b1; ba.in_inst = inst; ba.in_pc = pc; sq_i.push_back(e);
        end
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((sel_e ? be.in_ready : ba.in_ready) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for pc=0x%0h", pc);
        end
        @(posedge clk);
        #1;
        ba.in_valid = 1'b0;
        be.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sq_i.size() == 0 && sq_e.size() == 0) break;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n = 1'b0;
        flush = 1'b0;
        ba.in_valid = 1'b0; ba.in_inst = '0; ba.in_pc = '0; ba.out_ready = 1'b1;
        be.in_valid = 1'b0; be.in_inst = '0; be.in_pc = '0; be.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(ba.out_valid), 64'd0);
        chk("rst_in_ready", 64'(ba.in_ready), 64'd1);
        chk("rst_fmt", 64'(ba.out_fmt), 64'd0);
        chk("rst_imm", 64'(ba.out_imm), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Format coverage, back to back
        send(0, 32'hFFF00093, 32'h100, mk(32'h100, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 0));
        chk("latency_valid", 64'(ba.out_valid), 64'd1);
        chk("latency_pc", 64'(ba.out_pc), 64'h100);
        send(0, 32'h0020A423, 32'h104, mk(32'h104, 0, 1, 2, 2, 0, 32'h8, 2, 0, 0));
        send(0, 32'hFE000EE3, 32'h108, mk(32'h108, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 3, 0, 0));
        send(0, 32'h123452B7, 32'h10C, mk(32'h10C, 5, 0, 0, 0, 0, 32'h12345000, 4, 1, 0));
        send(0, 32'h0000006F, 32'h110, mk(32'h110, 0, 0, 0, 0, 0, 32'h0, 5, 0, 0));
        send(0, 32'h00000000, 32'h114, mk(32'h114, 0, 0, 0, 0, 0, 32'h0, 7, 0, 1));
        send(0, 32'h402081B3, 32'h118, mk(32'h118, 3, 1, 2, 0, 7'h20, 32'h0, 0, 1, 0));
        send(0, 32'hFFDFF0EF, 32'h11C, mk(32'h11C, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 5, 1, 0));
        drain(20);

        // Reduced register file
        send(1, 32'h00208833, 32'h400, mk(32'h400, 0, 1, 2, 0, 0, 32'h0, 0, 0, 1));
        send(1, 32'h00208733, 32'h404, mk(32'h404, 14, 1, 2, 0, 0, 32'h0, 0, 1, 0));
        drain(20);

        // Back-pressure: stall 3 cycles from the second output
        base = out_count;
        fork
            begin
                for (int n = 0; n < 50; n++) begin
                    @(posedge clk);
                    if (out_count != base) break;
                end
                #1 ba.out_ready = 1'b0;
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 64'(ba.in_ready), 64'd0);
                chk("stall_out_valid", 64'(ba.out_valid), 64'd1);
                @(posedge clk);
                #1 ba.out_ready = 1'b1;
                @(negedge clk);
                chk("dead_cycle_in_ready", 64'(ba.in_ready), 64'd0);
                @(negedge clk);
                chk("recover_in_ready", 64'(ba.in_ready), 64'd1);
            end
            begin
                send(0, 32'hFFF00093, 32'h200, mk(32'h200, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 0));
                send(0, 32'h0020A423, 32'h204, mk(32'h204, 0, 1, 2, 2, 0, 32'h8, 2, 0, 0));
                send(0, 32'hFE000EE3, 32'h208, mk(32'h208, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 3, 0, 0));
                send(0, 32'h123452B7, 32'h20C, mk(32'h20C, 5, 0, 0, 0, 0, 32'h12345000, 4, 1, 0));
                send(0, 32'h402081B3, 32'h210, mk(32'h210, 3, 1, 2, 0, 7'h20, 32'h0, 0, 1, 0));
                send(0, 32'hFFDFF0EF, 32'h214, mk(32'h214, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 5, 1, 0));
            end
        join
        drain(30);
        chk("burst_count", 64'(out_count - base), 64'd6);
        chk("burst_queue_empty", 64'(sq_i.size()), 64'd0);

        // Flush with both registers full and an input offered
        ba.out_ready = 1'b0;
        send(0, 32'hFFF00093, 32'h500, mk(32'h500, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 0));
        send(0, 32'h0020A423, 32'h504, mk(32'h504, 0, 1, 2, 2, 0, 32'h8, 2, 0, 0));
        chk("full_in_ready", 64'(ba.in_ready), 64'd0);
        ba.in_valid = 1'b1; ba.in_inst = 32'h123452B7; ba.in_pc = 32'h508;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        ba.in_valid = 1'b0;
        chk("flush_out_valid", 64'(ba.out_valid), 64'd0);
        chk("flush_in_ready", 64'(ba.in_ready), 64'd1);
        sq_i.delete();
        ba.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset with an entry held in main
        ba.out_ready = 1'b0;
        send(0, 32'h123452B7, 32'h300, mk(32'h300, 5, 0, 0, 0, 0, 32'h12345000, 4, 1, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(ba.out_valid), 64'd0);
        chk("async_rst_pc", 64'(ba.out_pc), 64'd0);
        chk("async_rst_imm", 64'(ba.out_imm), 64'd0);
        chk("async_rst_rd", 64'(ba.out_rd), 64'd0);
        chk("async_rst_in_ready", 64'(ba.in_ready), 64'd1);
        sq_i.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ba.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(0, 32'h0000006F, 32'h310, mk(32'h310, 0, 0, 0, 0, 0, 32'h0, 5, 0, 0));
        drain(20);
        chk("final_queue_empty", 64'(sq_i.size() + sq_e.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
